udp_tx_arbiter: RTL and testbench

//  Shares the single UDP core transmit port between NREQ requesters (e.g. the rx-triggered reply

---
 rtl/udp_tx_arb_pkg.sv | 16 +
 rtl/udp_tx_arbiter_if.sv | 38 +++
 rtl/udp_payload_serializer.sv | 39 +++
 rtl/udp_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_tx_arb_pkg.sv
// Shared widths and FSM encoding for the UDP transmit arbiter.
package udp_tx_arb_pkg;
    localparam int IP_W = 32;
    localparam int PORT_W = 16;
    localparam int BYTE_W = 8;
    localparam int PAYLOAD_BYTES_DEF = 5;
    localparam int ST_W = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Requester bundle plus UDP core transmit port seen by the arbiter.
interface udp_tx_arbiter_if #(
    parameter int NREQ = 2,
    parameter int PAYLOAD_BYTES = 5
);
    import udp_tx_arb_pkg::*;

    logic [NREQ-1:0]                      req_valid;
    logic [NREQ*IP_W-1:0]                 req_ip;
    logic [NREQ*PORT_W-1:0]               req_port;
    logic [NREQ*PAYLOAD_BYTES*BYTE_W-1:0] req_data;
    logic [NREQ-1:0]                      req_grant;
    logic [NREQ-1:0]                      req_done;
    logic [NREQ-1:0]                      req_err;
    logic [IP_W-1:0]                      tx_ip_o;
    logic [PORT_W-1:0]                    tx_dst_port_o;
    logic [BYTE_W-1:0]                    tx_data_o;
    logic                                 tx_data_av_o;
    logic                                 tx_req_o;
    logic                                 tx_req_rdy_i;
    logic                                 tx_data_rdy_i;

    modport master (
        input  req_valid, req_ip, req_port, req_data,
        input  tx_req_rdy_i, tx_data_rdy_i,
        output req_grant, req_done, req_err,
        output tx_ip_o, tx_dst_port_o, tx_data_o,
        output tx_data_av_o, tx_req_o
    );

    modport slave (
        output req_valid, req_ip, req_port, req_data,
        output tx_req_rdy_i, tx_data_rdy_i,
        input  req_grant, req_done, req_err,
        input  tx_ip_o, tx_dst_port_o, tx_data_o,
        input  tx_data_av_o, tx_req_o
    );
endinterface

// File: rtl/udp_payload_serializer.sv
// Fixed-length payload shift register, MSB byte first, with byte counter.
module udp_payload_serializer
    import udp_tx_arb_pkg::*;
#(
    parameter int PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic                              clr,
    input  logic                              shift,
    input  logic [PAYLOAD_BYTES*BYTE_W-1:0]   din,
    output logic [BYTE_W-1:0]                 byte_out,
    output logic                              last
);
    localparam int W = PAYLOAD_BYTES * BYTE_W;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);

    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt <= '0;
        end else if (load) begin
            shreg <= din;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift) begin
            shreg <= shreg << BYTE_W;
            cnt <= cnt + 1'b1;
        end
    end

    assign byte_out = shreg[W-1 -: BYTE_W];
    assign last = (cnt == CW'(PAYLOAD_BYTES - 1));
endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin share of the UDP core tx port with per-transfer timeout.
// TX_ARB_FIXED_PRIO_EN: requester 0 always wins, rr among the rest.
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
    parameter int TIMEOUT = 50000
) (
    input  logic            clk50m,
    input  logic            rst,
    udp_tx_arbiter_if.master bus
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = PAYLOAD_BYTES * BYTE_W;

    state_t          state;
    logic [PW-1:0]   rr;
    logic [PW-1:0]   w;
    logic [PW-1:0]   win;
    logic [PW-1:0]   nxt;
    logic            any;
    logic [TW-1:0]   tcnt;
    logic            tmo;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
    logic [NREQ-1:0] w_oh;
    logic [IP_W-1:0] ip;
    logic [PORT_W-1:0] port;
    logic [BYTE_W-1:0] data;
    logic            av;
    logic            req;
    logic            load;
    logic            clr;
    logic            shift;
    logic [BYTE_W-1:0] ser_byte;
    logic            ser_last;

    always_comb begin
        int idx;
        int base;
        idx = 0;
        base = 0;
        win = '0;
        any = 1'b0;
`ifdef TX_ARB_FIXED_PRIO_EN
        if (bus.req_valid[0]) begin
            any = 1'b1;
        end else begin
            base = (rr == '0) ? 1 : int'(rr);
            for (int k = 0; k < NREQ - 1; k++) begin
                idx = base + k;
                if (idx >= NREQ) idx = idx - (NREQ - 1);
                if (!any && bus.req_valid[idx]) begin
                    any = 1'b1;
                    win = PW'(idx);
                end
            end
        end
`else
        base = int'(rr);
        for (int k = 0; k < NREQ; k++) begin
            idx = base + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && bus.req_valid[idx]) begin
                any = 1'b1;
                win = PW'(idx);
            end
        end
`endif
    end

    // Pointer moves past the last served requester; 0 is skipped in fixed-prio builds.
    always_comb begin
`ifdef TX_ARB_FIXED_PRIO_EN
        nxt = (int'(w) + 1 >= NREQ) ? PW'(1) : PW'(int'(w) + 1);
`else
        nxt = (int'(w) + 1 >= NREQ) ? '0 : PW'(int'(w) + 1);
`endif
    end

    assign w_oh = {{(NREQ-1){1'b0}}, 1'b1} << w;
    assign tmo = (tcnt == TW'(TIMEOUT - 1));
    assign load = (state == S_IDLE) && any;
    assign clr = (state == S_WAIT_RDY) && bus.tx_req_rdy_i;
    assign shift = (state == S_SEND) && bus.tx_data_rdy_i;

    udp_payload_serializer #(
        .PAYLOAD_BYTES(PAYLOAD_BYTES)
    ) u_ser (
        .clk      (clk50m),
        .rst      (rst),
        .load     (load),
        .clr      (clr),
        .shift    (shift),
        .din      (bus.req_data[DW*win +: DW]),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    always_ff @(posedge clk50m) begin
        if (rst) begin
            state <= S_IDLE;
            rr <= '0;
            w <= '0;
            tcnt <= '0;
            grant <= '0;
            done <= '0;
            err <= '0;
            ip <= '0;
            port <= '0;
            data <= '0;
            av <= 1'b0;
            req <= 1'b0;
        end else begin
            grant <= '0;
            done <= '0;
            err <= '0;
            unique case (state)
                S_IDLE: begin
                    if (any) begin
                        w <= win;
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        ip <= bus.req_ip[IP_W*win +: IP_W];
                        port <= bus.req_port[PORT_W*win +: PORT_W];
                        tcnt <= '0;
                        state <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (bus.tx_req_rdy_i) begin
                        state <= S_SEND;
                    end else if (tmo) begin
                        err <= w_oh;
                        rr <= nxt;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (bus.tx_data_rdy_i) begin
                        data <= ser_byte;
                        av <= 1'b1;
                        if (ser_last) begin
                            tcnt <= '0;
                            state <= S_START;
                        end
                    end else begin
                        av <= 1'b0;
                    end
                end
                S_START: begin
                    av <= 1'b0;
                    if (bus.tx_req_rdy_i) begin
                        req <= 1'b1;
                        state <= S_DONE;
                    end else if (tmo) begin
                        err <= w_oh;
                        rr <= nxt;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    req <= 1'b0;
                    done <= w_oh;
                    rr <= nxt;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_grant = grant;
    assign bus.req_done = done;
    assign bus.req_err = err;
    assign bus.tx_ip_o = ip;
    assign bus.tx_dst_port_o = port;
    assign bus.tx_data_o = data;
    assign bus.tx_data_av_o = av;
    assign bus.tx_req_o = req;
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: frames queued at request time,
// checked on grant, bytes, tx request and done/err pulses.
module tb_udp_tx_arbiter;
    localparam int NR = 2;
    localparam int PB = 5;
    localparam int TMO = 20;

    typedef struct {
        int          idx;
        logic [31:0] ip;
        logic [15:0] port;
        logic [39:0] data;
        bit          err;
    } frame_t;

    logic clk50m;
    logic rst;

    udp_tx_arbiter_if #(.NREQ(NR), .PAYLOAD_BYTES(PB)) bus ();

    udp_tx_arbiter #(
        .NREQ(NR),
        .PAYLOAD_BYTES(PB),
        .TIMEOUT(TMO)
    ) dut (
        .clk50m (clk50m),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    frame_t     exp_q[$];
    logic [7:0] byte_q[$];
    frame_t     cur;
    bit         cur_active;
    int         pend[NR];
    int         ncmp;
    int         nerr;
    int         ends;
    int         av_cnt;
    int         treq_cnt;
    bit         toggle;
    bit         hold_start;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic post(input int i, input logic [31:0] ip,
                        input logic [15:0] port, input logic [39:0] d,
                        input bit e);
        frame_t f;
        f.idx = i;
        f.ip = ip;
        f.port = port;
        f.data = d;
        f.err = e;
        exp_q.push_back(f);
        bus.req_ip[32*i +: 32] = ip;
        bus.req_port[16*i +: 16] = port;
        bus.req_data[40*i +: 40] = d;
        pend[i]++;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic tick();
        int gi;
        @(negedge clk50m);
        if (!rst) begin
            if (|bus.req_err) begin
                if (cur_active) begin
                    chk("err_pulse", bus.req_err,
                        cur.err ? oh(cur.idx) : '0);
                    chk("err_no_treq", treq_cnt, 0);
                end else begin
                    chk("err_unexp", bus.req_err, 0);
                end
                cur_active = 0;
                byte_q.delete();
                ends++;
            end
            if (|bus.req_done) begin
                if (cur_active) begin
                    chk("done_pulse", bus.req_done,
                        cur.err ? '0 : oh(cur.idx));
                    chk("done_av_cnt", av_cnt, PB);
                    chk("done_treq_cnt", treq_cnt, 1);
                    chk("done_bytes_left", byte_q.size(), 0);
                end else begin
                    chk("done_unexp", bus.req_done, 0);
                end
                cur_active = 0;
                ends++;
            end
            if (bus.tx_req_o) begin
                treq_cnt++;
                chk("treq_ok", bus.tx_req_o, cur_active && !cur.err);
                chk("treq_after_bytes", av_cnt, PB);
            end
            if (bus.tx_data_av_o) begin
                av_cnt++;
                if (byte_q.size() == 0)
                    chk("byte_unexp", bus.tx_data_av_o, 0);
                else
                    chk("byte", bus.tx_data_o, byte_q.pop_front());
            end
            if (|bus.req_grant) begin
                chk("grant_vs_done", bus.req_done, 0);
                gi = 0;
                for (int i = 0; i < NR; i++)
                    if (bus.req_grant[i]) gi = i;
                if (exp_q.size() == 0) begin
                    chk("grant_unexp", bus.req_grant, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant", bus.req_grant, oh(cur.idx));
                    chk("tx_ip", bus.tx_ip_o, cur.ip);
                    chk("tx_port", bus.tx_dst_port_o, cur.port);
                    cur_active = 1;
                    av_cnt = 0;
                    treq_cnt = 0;
                    for (int b = PB - 1; b >= 0; b--)
                        byte_q.push_back(cur.data[8*b +: 8]);
                end
                if (pend[gi] > 0) pend[gi]--;
                if (pend[gi] == 0) bus.req_valid[gi] = 1'b0;
            end
        end
        if (toggle) bus.tx_data_rdy_i = ~bus.tx_data_rdy_i;
        if (hold_start && bus.tx_data_av_o) bus.tx_req_rdy_i = 1'b0;
    endtask

    task automatic wait_ends(input int target, input int budget);
        for (int i = 0; i < budget && ends < target; i++) tick();
        chk("frames_ended", ends, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_outputs",
            {bus.req_grant, bus.req_done, bus.req_err, bus.tx_ip_o,
             bus.tx_dst_port_o, bus.tx_data_o, bus.tx_data_av_o,
             bus.tx_req_o}, 64'h0);
        rst = 1'b0;
        exp_q.delete();
        byte_q.delete();
        cur_active = 0;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        bus.req_valid = '0;
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        ends = 0;
        av_cnt = 0;
        treq_cnt = 0;
        toggle = 0;
        hold_start = 0;
        cur_active = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_ip = '0;
        bus.req_port = '0;
        bus.req_data = '0;
        bus.tx_req_rdy_i = 1'b1;
        bus.tx_data_rdy_i = 1'b1;
        do_reset();

        // single request, grant visible one cycle later
        post(0, 32'hC0A80A01, 16'd1234, 40'h7472697701, 0);
        tick();
        chk("grant_latency", bus.req_grant, 2'b01);
        wait_ends(1, 40);

        // both valid from rr=0
        do_reset();
`ifdef TX_ARB_FIXED_PRIO_EN
        post(0, 32'h0A000001, 16'd5000, 40'h1122334455, 0);
        post(0, 32'h0A000001, 16'd5000, 40'h1122334455, 0);
        post(1, 32'h0A000002, 16'd6000, 40'hA1B2C3D4E5, 0);
        post(1, 32'h0A000002, 16'd6000, 40'hA1B2C3D4E5, 0);
`else
        post(0, 32'h0A000001, 16'd5000, 40'h1122334455, 0);
        post(1, 32'h0A000002, 16'd6000, 40'hA1B2C3D4E5, 0);
        post(0, 32'h0A000001, 16'd5000, 40'h1122334455, 0);
        post(1, 32'h0A000002, 16'd6000, 40'hA1B2C3D4E5, 0);
`endif
        wait_ends(ends + 4, 200);

        // data ready toggling during SEND
        toggle = 1;
        post(1, 32'hDEADBEEF, 16'h8001, 40'h0102030405, 0);
        wait_ends(ends + 1, 100);
        toggle = 0;
        bus.tx_data_rdy_i = 1'b1;

        // core never ready for the tx request
        hold_start = 1;
        post(0, 32'h01020304, 16'd77, 40'hCAFEBABE99, 1);
        wait_ends(ends + 1, 100);
        hold_start = 0;
        bus.tx_req_rdy_i = 1'b1;
        post(0, 32'h05060708, 16'd88, 40'h5A5A5AA5A5, 0);
        wait_ends(ends + 1, 60);

        // core never ready before the payload
        bus.tx_req_rdy_i = 1'b0;
        post(1, 32'h09090909, 16'd99, 40'hFFEEDDCCBB, 1);
        wait_ends(ends + 1, 60);
        bus.tx_req_rdy_i = 1'b1;

        // reset mid-SEND, then a fresh frame from byte 0
        post(0, 32'hAABBCCDD, 16'd4321, 40'h1020304050, 0);
        for (int i = 0; i < 40 && av_cnt < 2; i++) tick();
        chk("reached_send", av_cnt, 2);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        post(1, 32'h11223344, 16'd2222, 40'h6162636465, 0);
        wait_ends(ends + 1, 60);

`ifdef TX_ARB_FIXED_PRIO_EN
        post(0, 32'h0A0A0A0A, 16'd10, 40'h0A0B0C0D0E, 0);
        post(0, 32'h0A0A0A0A, 16'd10, 40'h0A0B0C0D0E, 0);
        post(1, 32'h0B0B0B0B, 16'd11, 40'h1A1B1C1D1E, 0);
        wait_ends(ends + 3, 150);
`endif

        for (int i = 0; i < 5; i++) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
